// File: rtl/lcd_pixel_packer.sv
// Packs pairs of RGB565 pixels into 32-bit words for the LCD pixel FIFO,
// counts pixels per frame and pulses o_frameError on framing violations.
module lcd_pixel_packer #(
  parameter int FRAME_PIXELS = 76800,
  parameter int COUNT_WIDTH  = 17
) (
  input  logic                   i_clock,
  input  logic                   i_nReset,
  input  logic [15:0]            i_pixelData,
  input  logic                   i_pixelValid,
  input  logic                   i_frameStart,
  output logic                   o_pixelReady,
  output logic [31:0]            o_fifoData,
  output logic                   o_fifoValid,
  input  logic                   i_fifoFull,
  output logic                   o_frameError,
  output logic [COUNT_WIDTH-1:0] o_pixelCount
);

  typedef enum logic {
    S_LOW,
    S_HIGH
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] FRAME_LEN = COUNT_WIDTH'(FRAME_PIXELS);
  localparam logic [COUNT_WIDTH-1:0] ONE       = COUNT_WIDTH'(1);

  state_t                  state_q, state_d;
  logic [15:0]             held_q, held_d;
  logic [31:0]             word_q, word_d;
  logic                    pending_q, pending_d;
  logic                    error_q, error_d;
  logic [COUNT_WIDTH-1:0]  count_q, count_d;
  logic                    accept;

  // A stalled word blocks new pixels, so a formed word can never be overwritten.
  assign o_pixelReady = !(pending_q && i_fifoFull);
  assign accept       = i_pixelValid && o_pixelReady;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_d   = state_q;
    held_d    = held_q;
    word_d    = word_q;
    pending_d = pending_q && i_fifoFull;
    error_d   = 1'b0;
    count_d   = count_q;

    if (accept) begin
      if (i_frameStart) begin
        // A half-filled word at a frame start is dropped rather than padded.
        count_d = ONE;
        error_d = ((count_q != '0) && (count_q != FRAME_LEN)) || (state_q == S_HIGH);
        held_d  = i_pixelData;
        state_d = S_HIGH;
      end else begin
        if (count_q == FRAME_LEN) begin
          error_d = 1'b1;
          count_d = ONE;
        end else begin
          count_d = count_q + ONE;
        end

        if (state_q == S_LOW) begin
          held_d  = i_pixelData;
          state_d = S_HIGH;
        end else begin
          word_d    = {i_pixelData, held_q};
          pending_d = 1'b1;
          state_d   = S_LOW;
        end
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so all flops sample together.
  always_ff @(posedge i_clock or negedge i_nReset) begin
    if (!i_nReset) begin
      state_q   <= S_LOW;
      held_q    <= '0;
      word_q    <= '0;
      pending_q <= 1'b0;
      error_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      held_q    <= held_d;
      word_q    <= word_d;
      pending_q <= pending_d;
      error_q   <= error_d;
      count_q   <= count_d;
    end
  end

  assign o_fifoData   = word_q;
  assign o_fifoValid  = pending_q;
  assign o_frameError = error_q;
  assign o_pixelCount = count_q;

endmodule
